key_sw_conditioner: RTL

Input conditioning stage directly upstream of the calculator top level. It synchronises and debounces the raw board push-buttons and slide switches, then presents clean levels and single-cycle press pulses to the number-entry and muxing logic. Every KEY press therefore produces exactly one add/negate/set action. With auto-repeat compiled in, a held key keeps producing actions at a steady rate.

---
 rtl/key_sw_conditioner_pkg.sv | 26 ++
 rtl/key_sw_conditioner_if.sv | 27 ++
 rtl/key_sw_conditioner_debounce_bit.sv | 50 +++++
 rtl/key_sw_conditioner.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/key_sw_conditioner_pkg.sv
// Shared types and helpers for the key/switch input conditioner.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package calc_input_pkg;

    // Per-key press tracking. Without auto-repeat only RELEASED and
    // HELD_DELAY are used, and HELD_DELAY then simply means "held".
    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        HELD_DELAY  = 2'd1,
        HELD_REPEAT = 2'd2
    } key_state_t;

    // Milliseconds to clock cycles, never less than one cycle so that a
    // slow clock or a tiny time still gives a usable terminal count.
    function automatic int ms_to_cyc(input int clk_hz, input int ms);
        longint cyc;
        cyc = (longint'(clk_hz) * longint'(ms)) / 1000;
        return (cyc < 1) ? 1 : int'(cyc);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_sw_conditioner_if.sv
// Board-side raw inputs and conditioned outputs of the key/switch conditioner.
// Latency: n/a (bundle of wires).
// Backpressure: none; all signals are free-running levels or one-cycle pulses.
interface key_sw_conditioner_if #(
    parameter int N_KEYS = 2,
    parameter int N_SW   = 10
);
    logic [N_KEYS-1:0] key_in;      // raw, active-low
    logic [N_SW-1:0]   sw_in;       // raw
    logic [N_KEYS-1:0] key_level;   // debounced, active-high
    logic [N_KEYS-1:0] key_press;   // one-cycle press / repeat pulses
    logic [N_SW-1:0]   sw_out;      // debounced
    logic              sw_changed;  // one-cycle pulse on any sw_out change
    logic              ready;       // settle phase finished

    // Board / consumer side.
    modport master (
        output key_in, sw_in,
        input  key_level, key_press, sw_out, sw_changed, ready
    );

    // Conditioner side.
    modport slave (
        input  key_in, sw_in,
        output key_level, key_press, sw_out, sw_changed, ready
    );
endinterface

// File: rtl/key_sw_conditioner_debounce_bit.sv
// One input bit: 2-FF synchroniser, stability counter, filtered flop, change strobe.
// Latency: a stable change reaches filt 2+DEB_CYC edges after it is first sampled.
// Backpressure: none; settle forces filt to follow the synchroniser directly.
module debounce_bit #(
    parameter int   DEB_CYC = 1,
    parameter logic INVERT  = 1'b0   // keys are active-low on the board
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic settle,
    output logic filt,
    output logic chg                 // combinational: filt flips on this edge
);
    localparam int CW = $clog2(DEB_CYC + 1);

    // Reset the synchroniser to the idle level, so an inverted key reads released.
    logic [1:0]    sync_q;
    logic          synced;
    logic [CW-1:0] cnt_q;
    logic          at_term;

    assign synced  = sync_q[1] ^ INVERT;
    assign at_term = (cnt_q == CW'(DEB_CYC - 1));
    assign chg     = !settle && (synced != filt) && at_term;

    // Two-stage synchroniser against the asynchronous board input.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {2{INVERT}};
        else       sync_q <= {sync_q[0], raw};
    end

    // Filtered value only moves after DEB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt  <= 1'b0;
            cnt_q <= '0;
        end else if (settle) begin
            filt  <= synced;
            cnt_q <= '0;
        end else if (synced == filt) begin
            cnt_q <= '0;
        end else if (at_term) begin
            filt  <= synced;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/key_sw_conditioner.sv
// Debounces keys/switches, generates press (and optional auto-repeat) pulses; macro KEY_AUTOREPEAT_EN.
// Latency: levels 2+DEB_CYC edges after first sample; KEY_PRESS in the same cycle KEY_LEVEL rises.
// Backpressure: none; pulses are dropped (not deferred) until ready is high.
module key_sw_conditioner
    import calc_input_pkg::*;
#(
    parameter int CLK_HZ          = 10000,
    parameter int DEBOUNCE_MS     = 20,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter int N_KEYS          = 2,
    parameter int N_SW            = 10
) (
    input  logic clk,
    input  logic reset,
    key_sw_conditioner_if.slave bus
);
    localparam int DEB_CYC = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
    localparam int SCNT_W  = $clog2(DEB_CYC + 1);

    logic [SCNT_W-1:0] settle_cnt;
    logic              settle;
    logic              ready_q;
    logic [N_KEYS-1:0] key_filt, key_chg, key_rise, key_fall;
    logic [N_SW-1:0]   sw_filt, sw_chg;
    logic [N_KEYS-1:0] key_press_q;
    logic              sw_changed_q;
    key_state_t        key_state [N_KEYS];

    assign settle = (settle_cnt != SCNT_W'(DEB_CYC));

    // Settle window after reset; ready follows one cycle after it closes.
    always_ff @(posedge clk) begin
        if (reset) begin
            settle_cnt <= '0;
            ready_q    <= 1'b0;
        end else begin
            if (settle) settle_cnt <= settle_cnt + SCNT_W'(1);
            ready_q <= !settle;
        end
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        debounce_bit #(.DEB_CYC(DEB_CYC), .INVERT(1'b1)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.key_in[i]),
            .settle (settle),
            .filt   (key_filt[i]),
            .chg    (key_chg[i])
        );
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        debounce_bit #(.DEB_CYC(DEB_CYC), .INVERT(1'b0)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.sw_in[i]),
            .settle (settle),
            .filt   (sw_filt[i]),
            .chg    (sw_chg[i])
        );
    end

    // A strobe with filt still low is a press edge, with filt high a release edge.
    assign key_rise = key_chg & ~key_filt;
    assign key_fall = key_chg &  key_filt;

`ifdef KEY_AUTOREPEAT_EN
    localparam int DLY_CYC  = ms_to_cyc(CLK_HZ, REPEAT_DELAY_MS);
    localparam int RATE_CYC = ms_to_cyc(CLK_HZ, REPEAT_RATE_MS);
    localparam int RCNT_W   = $clog2(max_int(DLY_CYC, RATE_CYC) + 1);

    logic [RCNT_W-1:0] rpt_cnt [N_KEYS];

    // Per-key press/auto-repeat FSM; until ready, track the loaded level with the delay timer held at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_KEYS; i++) begin
                key_state[i] <= RELEASED;
                rpt_cnt[i]   <= '0;
            end
            key_press_q <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                key_press_q[i] <= 1'b0;
                if (!ready_q) begin
                    key_state[i] <= key_filt[i] ? HELD_DELAY : RELEASED;
                    rpt_cnt[i]   <= '0;
                end else begin
                    case (key_state[i])
                        RELEASED: begin
                            if (key_rise[i]) begin
                                key_press_q[i] <= 1'b1;
                                key_state[i]   <= HELD_DELAY;
                                rpt_cnt[i]     <= '0;
                            end
                        end
                        HELD_DELAY: begin
                            if (key_fall[i]) begin
                                key_state[i] <= RELEASED;
                                rpt_cnt[i]   <= '0;
                            end else if (rpt_cnt[i] == RCNT_W'(DLY_CYC - 1)) begin
                                key_press_q[i] <= 1'b1;
                                key_state[i]   <= HELD_REPEAT;
                                rpt_cnt[i]     <= '0;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + RCNT_W'(1);
                            end
                        end
                        HELD_REPEAT: begin
                            if (key_fall[i]) begin
                                key_state[i] <= RELEASED;
                                rpt_cnt[i]   <= '0;
                            end else if (rpt_cnt[i] == RCNT_W'(RATE_CYC - 1)) begin
                                key_press_q[i] <= 1'b1;
                                rpt_cnt[i]     <= '0;
                            end else begin
                                rpt_cnt[i] <= rpt_cnt[i] + RCNT_W'(1);
                            end
                        end
                        default: begin
                            key_state[i] <= RELEASED;
                            rpt_cnt[i]   <= '0;
                        end
                    endcase
                end
            end
        end
    end
`else
    // Repeat timing has no effect in this build; the parameters are only
    // sanity-checked so that a nonsensical configuration stays visible.
    if (REPEAT_DELAY_MS < 0 || REPEAT_RATE_MS < 0) begin : g_bad_repeat_cfg
    end

    // Per-key press FSM: one pulse per debounced press, HELD_DELAY means held.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_KEYS; i++) key_state[i] <= RELEASED;
            key_press_q <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                key_press_q[i] <= 1'b0;
                if (!ready_q) begin
                    key_state[i] <= key_filt[i] ? HELD_DELAY : RELEASED;
                end else begin
                    case (key_state[i])
                        RELEASED: begin
                            if (key_rise[i]) begin
                                key_press_q[i] <= 1'b1;
                                key_state[i]   <= HELD_DELAY;
                            end
                        end
                        default: begin
                            if (key_fall[i]) key_state[i] <= RELEASED;
                        end
                    endcase
                end
            end
        end
    end
`endif

    // Any switch bit changing on this edge gives a single pulse.
    always_ff @(posedge clk) begin
        if (reset) sw_changed_q <= 1'b0;
        else       sw_changed_q <= ready_q && (|sw_chg);
    end

    assign bus.key_level  = key_filt;
    assign bus.key_press  = key_press_q;
    assign bus.sw_out     = sw_filt;
    assign bus.sw_changed = sw_changed_q;
    assign bus.ready      = ready_q;
endmodule
